clint_arb: RTL and testbench

Parametrised successor to the core-local interrupt/trap sequencer. Arbitrates synchronous exceptions (ecall, ebreak, illegal instruction), NUM_IRQ masked asynchronous interrupt lines and mret. Sequences the required machine-mode CSR writes (mepc, mcause, mstatus) over a single CSR write port, then issues a one-cycle redirect to the fetch stage. Sits beside the execute stage, between decode/execute and the CSR file.

---
 rtl/clint_pkg.sv | 34 +++
 rtl/clint_prio_enc.sv | 27 ++
 rtl/clint_arb.sv | 199 +++++++++++++++++++
 tb/tb_clint_arb.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clint_pkg.sv
// Shared definitions for the core-local interrupt/trap sequencer: FSM states,
// machine-mode CSR addresses, synchronous cause codes and mstatus bit positions.
package clint_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_W_MEPC,
    ST_W_MCAUSE,
    ST_W_MSTAT,
    ST_R_MSTAT,
    ST_REDIR
  } clint_state_e;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int CAUSE_ILLEGAL = 2;
  localparam int CAUSE_EBREAK  = 3;
  localparam int CAUSE_ECALL   = 11;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Index width for an n-entry encoder; a single source still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/clint_prio_enc.sv
// Lowest-index-wins priority encoder for the interrupt request vector.
// Produces a valid flag, the binary index of the winner and its one-hot form.
module clint_prio_enc
  import clint_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req,
  output logic             valid,
  output logic [IDX_W-1:0] index,
  output logic [N-1:0]     onehot
);

  // Two's-complement trick isolates the lowest set bit.
  always_comb begin
    valid  = |req;
    onehot = req & (~req + N'(1));
    index  = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        index = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/clint_arb.sv
// Trap/interrupt/mret sequencer: writes mepc, mcause, mstatus over one CSR port
// and then redirects fetch. Optional vectored interrupt targets: CLINT_VECTORED_EN.
module clint_arb
  import clint_pkg::*;
#(
  parameter int XLEN           = 32,
  parameter int NUM_IRQ        = 8,
  parameter int CSR_ADDR_W     = 12,
  parameter int IRQ_CAUSE_BASE = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  ecall_i,
  input  logic                  ebreak_i,
  input  logic                  illegal_i,
  input  logic                  mret_i,
  input  logic [XLEN-1:0]       inst_addr_i,
  input  logic                  jump_flag_i,
  input  logic [XLEN-1:0]       jump_addr_i,
  input  logic [NUM_IRQ-1:0]    irq_i,
  input  logic [NUM_IRQ-1:0]    csr_mie_i,
  input  logic [XLEN-1:0]       csr_mstatus_i,
  input  logic [XLEN-1:0]       csr_mtvec_i,
  input  logic [XLEN-1:0]       csr_mepc_i,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_waddr_o,
  output logic [XLEN-1:0]       csr_wdata_o,
  output logic [NUM_IRQ-1:0]    irq_ack_o,
  output logic                  busy_o,
  output logic                  int_flag_o,
  output logic [XLEN-1:0]       int_addr_o
);

  localparam int IRQ_IDX_W = idx_width(NUM_IRQ);

  clint_state_e state_q, state_d;

  logic [XLEN-1:0]      cause_q;
  logic [XLEN-1:0]      epc_q;
  logic [XLEN-1:0]      ret_addr_q;
  logic                 mret_q;

  logic                 enc_valid;
  logic [IRQ_IDX_W-1:0] enc_idx;
  logic [NUM_IRQ-1:0]   enc_onehot;

  logic                 sync_exc;
  logic                 irq_pend;
  logic                 take_irq;
  logic [XLEN-1:0]      exc_cause;
  logic [XLEN-1:0]      irq_cause;
  logic [XLEN-1:0]      trap_mstatus;
  logic [XLEN-1:0]      mret_mstatus;
  logic [XLEN-1:0]      trap_base;
  logic [XLEN-1:0]      trap_target;

  clint_prio_enc #(
    .N     (NUM_IRQ),
    .IDX_W (IRQ_IDX_W)
  ) u_prio_enc (
    .req    (irq_i & csr_mie_i),
    .valid  (enc_valid),
    .index  (enc_idx),
    .onehot (enc_onehot)
  );

  assign sync_exc = illegal_i | ebreak_i | ecall_i;
  assign irq_pend = csr_mstatus_i[MSTATUS_MIE] & enc_valid;
  assign take_irq = !rst_i && (state_q == ST_IDLE) && !sync_exc && irq_pend;

  assign exc_cause = illegal_i ? XLEN'(CAUSE_ILLEGAL) :
                     ebreak_i  ? XLEN'(CAUSE_EBREAK)  : XLEN'(CAUSE_ECALL);
  assign irq_cause = {1'b1, (XLEN-1)'(IRQ_CAUSE_BASE) + (XLEN-1)'(enc_idx)};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (sync_exc || irq_pend) begin
          state_d = ST_W_MEPC;
        end else if (mret_i) begin
          state_d = ST_R_MSTAT;
        end
      end
      ST_W_MEPC:   state_d = ST_W_MCAUSE;
      ST_W_MCAUSE: state_d = ST_W_MSTAT;
      ST_W_MSTAT:  state_d = ST_REDIR;
      ST_R_MSTAT:  state_d = ST_REDIR;
      ST_REDIR:    state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  // Cause/epc are captured only on the IDLE cycle that starts a sequence;
  // the mret return address is captured in R_MSTAT for the following redirect.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cause_q    <= '0;
      epc_q      <= '0;
      ret_addr_q <= '0;
      mret_q     <= 1'b0;
    end else begin
      if (state_q == ST_IDLE) begin
        if (sync_exc) begin
          cause_q <= exc_cause;
          epc_q   <= inst_addr_i;
          mret_q  <= 1'b0;
        end else if (irq_pend) begin
          cause_q <= irq_cause;
          epc_q   <= jump_flag_i ? jump_addr_i : inst_addr_i;
          mret_q  <= 1'b0;
        end else if (mret_i) begin
          mret_q  <= 1'b1;
        end
      end
      if (state_q == ST_R_MSTAT) begin
        ret_addr_q <= csr_mepc_i;
      end
    end
  end

  always_comb begin
    trap_mstatus                                = csr_mstatus_i;
    trap_mstatus[MSTATUS_MPIE]                  = csr_mstatus_i[MSTATUS_MIE];
    trap_mstatus[MSTATUS_MIE]                   = 1'b0;
    trap_mstatus[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;

    mret_mstatus               = csr_mstatus_i;
    mret_mstatus[MSTATUS_MIE]  = csr_mstatus_i[MSTATUS_MPIE];
    mret_mstatus[MSTATUS_MPIE] = 1'b1;
  end

  assign trap_base = {csr_mtvec_i[XLEN-1:2], 2'b00};

`ifdef CLINT_VECTORED_EN
  // Vectored mode applies to interrupts only; the cause code drops the interrupt bit.
  always_comb begin
    trap_target = trap_base;
    if ((csr_mtvec_i[1:0] == 2'b01) && cause_q[XLEN-1]) begin
      trap_target = trap_base + ({1'b0, cause_q[XLEN-2:0]} << 2);
    end
  end
`else
  logic unused_mtvec_mode;
  assign unused_mtvec_mode = ^csr_mtvec_i[1:0];
  assign trap_target       = trap_base;
`endif

  always_comb begin
    csr_we_o    = 1'b0;
    csr_waddr_o = '0;
    csr_wdata_o = '0;
    irq_ack_o   = '0;
    int_flag_o  = 1'b0;
    int_addr_o  = '0;
    busy_o      = (state_q != ST_IDLE);
    unique case (state_q)
      ST_IDLE: begin
        if (take_irq) begin
          irq_ack_o = enc_onehot;
        end
      end
      ST_W_MEPC: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_W'(CSR_MEPC);
        csr_wdata_o = epc_q;
      end
      ST_W_MCAUSE: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_W'(CSR_MCAUSE);
        csr_wdata_o = cause_q;
      end
      ST_W_MSTAT: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_W'(CSR_MSTATUS);
        csr_wdata_o = trap_mstatus;
      end
      ST_R_MSTAT: begin
        csr_we_o    = 1'b1;
        csr_waddr_o = CSR_ADDR_W'(CSR_MSTATUS);
        csr_wdata_o = mret_mstatus;
      end
      ST_REDIR: begin
        int_flag_o = 1'b1;
        int_addr_o = mret_q ? ret_addr_q : trap_target;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_clint_arb.sv
// Self-checking bench for clint_arb: directed literal scenarios plus randomized
// traffic compared every cycle against a queue-based behavioural model.
module tb_clint_arb;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        ecall_i = 1'b0, ebreak_i = 1'b0, illegal_i = 1'b0, mret_i = 1'b0;
  logic [31:0] inst_addr_i = '0;
  logic        jump_flag_i = 1'b0;
  logic [31:0] jump_addr_i = '0;
  logic [7:0]  irq_i = '0, csr_mie_i = '0;
  logic [31:0] csr_mstatus_i = '0, csr_mtvec_i = '0, csr_mepc_i = '0;
  logic        csr_we_o;
  logic [11:0] csr_waddr_o;
  logic [31:0] csr_wdata_o;
  logic [7:0]  irq_ack_o;
  logic        busy_o, int_flag_o;
  logic [31:0] int_addr_o;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  typedef struct packed {
    logic        busy;
    logic        we;
    logic [11:0] addr;
    logic [31:0] data;
    logic        flag;
    logic [31:0] iaddr;
    logic [7:0]  ack;
  } exp_t;

  exp_t q[$];

  clint_arb #(
    .XLEN(32), .NUM_IRQ(8), .CSR_ADDR_W(12), .IRQ_CAUSE_BASE(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .ecall_i(ecall_i), .ebreak_i(ebreak_i), .illegal_i(illegal_i), .mret_i(mret_i),
    .inst_addr_i(inst_addr_i), .jump_flag_i(jump_flag_i), .jump_addr_i(jump_addr_i),
    .irq_i(irq_i), .csr_mie_i(csr_mie_i), .csr_mstatus_i(csr_mstatus_i),
    .csr_mtvec_i(csr_mtvec_i), .csr_mepc_i(csr_mepc_i),
    .csr_we_o(csr_we_o), .csr_waddr_o(csr_waddr_o), .csr_wdata_o(csr_wdata_o),
    .irq_ack_o(irq_ack_o), .busy_o(busy_o), .int_flag_o(int_flag_o), .int_addr_o(int_addr_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] trap_mstat(input logic [31:0] m);
    return (m & ~32'h0000_1888) | 32'h0000_1800 | (m[3] ? 32'h80 : 32'h0);
  endfunction

  function automatic logic [31:0] mret_mstat(input logic [31:0] m);
    return (m & ~32'h0000_0088) | 32'h80 | (m[7] ? 32'h8 : 32'h0);
  endfunction

  // Decide what the current idle cycle starts and queue the whole expected sequence.
  task automatic plan_event(output exp_t now);
    exp_t        e;
    int          k;
    logic        sync;
    logic [31:0] cause, epc, target;
    now  = '0;
    sync = illegal_i | ebreak_i | ecall_i;
    k    = -1;
    if (csr_mstatus_i[3])
      for (int i = 0; i < 8; i++)
        if (k < 0 && irq_i[i] && csr_mie_i[i]) k = i;
    if (sync || k >= 0) begin
      if (illegal_i)     cause = 32'd2;
      else if (ebreak_i) cause = 32'd3;
      else if (ecall_i)  cause = 32'd11;
      else begin
        cause   = 32'h8000_0000 + 32'(16 + k);
        now.ack = 8'(1 << k);
      end
      epc    = (!sync && jump_flag_i) ? jump_addr_i : inst_addr_i;
      target = csr_mtvec_i & ~32'h3;
`ifdef CLINT_VECTORED_EN
      if (!sync && csr_mtvec_i[1:0] == 2'b01) target = target + 32'(4 * (16 + k));
`endif
      e = '0; e.busy = 1; e.we = 1; e.addr = 12'h341; e.data = epc;                       q.push_back(e);
      e = '0; e.busy = 1; e.we = 1; e.addr = 12'h342; e.data = cause;                     q.push_back(e);
      e = '0; e.busy = 1; e.we = 1; e.addr = 12'h300; e.data = trap_mstat(csr_mstatus_i); q.push_back(e);
      e = '0; e.busy = 1; e.flag = 1; e.iaddr = target;                                   q.push_back(e);
    end else if (mret_i) begin
      e = '0; e.busy = 1; e.we = 1; e.addr = 12'h300; e.data = mret_mstat(csr_mstatus_i); q.push_back(e);
      e = '0; e.busy = 1; e.flag = 1; e.iaddr = csr_mepc_i;                               q.push_back(e);
    end
  endtask

  always @(negedge clk_i) begin
    if (chk_en) begin
      exp_t cur;
      if (q.size() == 0) begin
        cur = '0;
        if (!rst_i) plan_event(cur);
      end else begin
        cur = q.pop_front();
        if (rst_i) q.delete();
      end
      checkOutput("m_busy",  32'(busy_o),      32'(cur.busy));
      checkOutput("m_we",    32'(csr_we_o),    32'(cur.we));
      checkOutput("m_waddr", 32'(csr_waddr_o), 32'(cur.addr));
      checkOutput("m_wdata", csr_wdata_o,      cur.data);
      checkOutput("m_flag",  32'(int_flag_o),  32'(cur.flag));
      checkOutput("m_iaddr", int_addr_o,       cur.iaddr);
      checkOutput("m_ack",   32'(irq_ack_o),   32'(cur.ack));
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic ec, input logic eb, input logic il, input logic mr,
                               input logic [7:0] irq, input logic [31:0] pc);
    ecall_i = ec; ebreak_i = eb; illegal_i = il; mret_i = mr; irq_i = irq; inst_addr_i = pc;
  endtask

  initial begin
    int r;
    tick();
    @(negedge clk_i);
    checkOutput("reset_busy", 32'(busy_o), 32'h0);
    checkOutput("reset_we",   32'(csr_we_o), 32'h0);
    checkOutput("reset_flag", 32'(int_flag_o), 32'h0);
    chk_en = 1'b1;

    // ecall at 0x100
    tick(); rst_i = 0; csr_mstatus_i = 32'h8; csr_mtvec_i = 32'h800; csr_mie_i = 8'hFF;
    applyStimulus(1, 0, 0, 0, 8'h0, 32'h100);
    @(negedge clk_i); checkOutput("ecall_n_busy", 32'(busy_o), 32'h0);
    tick(); applyStimulus(0, 0, 0, 0, 8'h0, 32'h0);
    @(negedge clk_i); checkOutput("ecall_mepc_addr", 32'(csr_waddr_o), 32'h341);
                      checkOutput("ecall_mepc_data", csr_wdata_o, 32'h100);
    tick(); @(negedge clk_i); checkOutput("ecall_mcause", csr_wdata_o, 32'd11);
    tick(); @(negedge clk_i); checkOutput("ecall_mstatus", csr_wdata_o, 32'h1880);
    tick(); @(negedge clk_i); checkOutput("ecall_flag", 32'(int_flag_o), 32'h1);
                              checkOutput("ecall_target", int_addr_o, 32'h800);
    tick(); @(negedge clk_i); checkOutput("ecall_done", 32'(busy_o), 32'h0);

    // irq with jump redirect in flight
    tick(); jump_flag_i = 1; jump_addr_i = 32'h240;
    applyStimulus(0, 0, 0, 0, 8'b0110, 32'h300);
    @(negedge clk_i); checkOutput("irq_ack", 32'(irq_ack_o), 32'h2);
    tick(); jump_flag_i = 0; applyStimulus(0, 0, 0, 0, 8'h0, 32'h0);
    @(negedge clk_i); checkOutput("irq_mepc", csr_wdata_o, 32'h240);
    tick(); @(negedge clk_i); checkOutput("irq_mcause", csr_wdata_o, 32'h8000_0011);
    tick(); tick(); @(negedge clk_i); checkOutput("irq_target", int_addr_o, 32'h800);
    tick();

    // masked irq
    csr_mstatus_i = 32'h0; applyStimulus(0, 0, 0, 0, 8'h1, 32'h0);
    @(negedge clk_i); checkOutput("mask_mie_busy", 32'(busy_o), 32'h0);
    tick(); csr_mstatus_i = 32'h8; csr_mie_i = 8'hFE;
    @(negedge clk_i); checkOutput("mask_en_busy", 32'(busy_o), 32'h0);
                      checkOutput("mask_en_ack", 32'(irq_ack_o), 32'h0);
    tick(); irq_i = 0; csr_mie_i = 8'hFF;

    // mret
    csr_mstatus_i = 32'h80; csr_mepc_i = 32'h104; applyStimulus(0, 0, 0, 1, 8'h0, 32'h0);
    @(negedge clk_i); checkOutput("mret_n_busy", 32'(busy_o), 32'h0);
    tick(); mret_i = 0;
    @(negedge clk_i); checkOutput("mret_waddr", 32'(csr_waddr_o), 32'h300);
                      checkOutput("mret_wdata", csr_wdata_o, 32'h88);
    tick(); @(negedge clk_i); checkOutput("mret_target", int_addr_o, 32'h104);
    tick();

    // ebreak wins over irq0, then MIE=0 blocks it
    csr_mstatus_i = 32'h8; applyStimulus(0, 1, 0, 0, 8'h1, 32'h200);
    @(negedge clk_i); checkOutput("ebrk_ack", 32'(irq_ack_o), 32'h0);
    tick(); ebreak_i = 0;
    @(negedge clk_i); checkOutput("ebrk_mepc", csr_wdata_o, 32'h200);
    tick(); @(negedge clk_i); checkOutput("ebrk_mcause", csr_wdata_o, 32'd3);
    tick(); tick(); tick(); csr_mstatus_i = 32'h1880;
    @(negedge clk_i); checkOutput("ebrk_blocked_busy", 32'(busy_o), 32'h0);
                      checkOutput("ebrk_blocked_ack", 32'(irq_ack_o), 32'h0);
    tick(); irq_i = 0; csr_mstatus_i = 32'h8;

    // reset during W_MCAUSE
    applyStimulus(1, 0, 0, 0, 8'h0, 32'h400);
    tick(); ecall_i = 0;
    tick(); rst_i = 1;
    @(negedge clk_i); checkOutput("rst_mcause_we", 32'(csr_we_o), 32'h1);
    tick(); rst_i = 0;
    @(negedge clk_i); checkOutput("rst_busy", 32'(busy_o), 32'h0);
                      checkOutput("rst_we", 32'(csr_we_o), 32'h0);
                      checkOutput("rst_wdata", csr_wdata_o, 32'h0);
    tick(); @(negedge clk_i); checkOutput("rst_no_mstat", 32'(csr_we_o), 32'h0);
                              checkOutput("rst_no_flag", 32'(int_flag_o), 32'h0);
    tick();

    // mtvec mode bits with irq0
    csr_mtvec_i = 32'h801; csr_mie_i = 8'h01; applyStimulus(0, 0, 0, 0, 8'h1, 32'h500);
    @(negedge clk_i); checkOutput("vec_ack", 32'(irq_ack_o), 32'h1);
    tick(); irq_i = 0; tick(); tick(); tick();
`ifdef CLINT_VECTORED_EN
    @(negedge clk_i); checkOutput("vec_target", int_addr_o, 32'h840);
`else
    @(negedge clk_i); checkOutput("vec_target", int_addr_o, 32'h800);
`endif

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      tick();
      rst_i = ($urandom_range(0, 299) == 0);
      r = $urandom_range(0, 15);
      illegal_i   = (r == 0) || (r == 5);
      ebreak_i    = (r == 1) || (r == 5);
      ecall_i     = (r == 2) || (r == 5);
      mret_i      = (r == 3) || (r == 4) || (r == 5);
      irq_i       = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h0;
      inst_addr_i = $urandom & ~32'h3;
      jump_flag_i = 1'($urandom_range(0, 1));
      jump_addr_i = $urandom;
      if (q.size() == 0) begin
        csr_mie_i     = 8'($urandom);
        csr_mstatus_i = $urandom;
        csr_mtvec_i   = $urandom;
        csr_mepc_i    = $urandom;
      end
    end
    tick(); rst_i = 0; applyStimulus(0, 0, 0, 0, 8'h0, 32'h0);
    repeat (8) tick();
    @(negedge clk_i);
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
